// File: rtl/calc_pkg.sv
// Opcodes and FSM state encodings shared by the accumulator engine and its datapath.
package calc_pkg;

  // Bit 1 selects abs, bit 2 swaps operand roles, bit 0 selects subtract.
  localparam logic [2:0] OP_ADD_AB = 3'b000;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_ABS_B  = 3'b01?;
  localparam logic [2:0] OP_ADD_BA = 3'b100;
  localparam logic [2:0] OP_SUB_BA = 3'b101;
  localparam logic [2:0] OP_ABS_A  = 3'b11?;

  typedef logic [0:0] state_t;
  localparam state_t ACCUM  = 1'b0;
  localparam state_t RESULT = 1'b1;

endpackage

// File: rtl/calc_accum_engine_alu.sv
// Combinational W-bit signed calculator: add/sub in either order or abs, wrapping, with per-op overflow.
// Zero latency; no flow control.
module calc_accum_engine_alu #(
  parameter int W = 16
) (
  input  logic [2:0]         op,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] r,
  output logic               ovf
);

  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] diff;
  logic signed [W-1:0] abs_src;

  always_comb begin
    x       = op[2] ? b : a;
    y       = op[2] ? a : b;
    abs_src = op[2] ? a : b;
    sum     = x + y;
    diff    = x - y;
    r       = '0;
    ovf     = 1'b0;
    if (op[1]) begin
      // Negating the most negative value wraps back onto itself; flag it.
      r   = abs_src[W-1] ? -abs_src : abs_src;
      ovf = abs_src[W-1] && (abs_src[W-2:0] == '0);
    end else if (op[0]) begin
      r   = diff;
      ovf = (x[W-1] != y[W-1]) && (diff[W-1] != x[W-1]);
    end else begin
      r   = sum;
      ovf = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
    end
  end

endmodule

// File: rtl/calc_accum_engine.sv
// Command-driven accumulator around the calculator datapath; result registered 1 cycle after the last beat.
// cmd_ready drops while a result waits; res_* held until res_ready, cmd_ready returns the cycle after.
module calc_accum_engine
  import calc_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [W-1:0]  cmd_data,
  input  logic          cmd_last,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          res_ovf,
  output logic [CW-1:0] res_count,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic          res_ovf_q, res_ovf_d;
  logic [CW-1:0] res_cnt_q, res_cnt_d;

  logic [W-1:0]  alu_r;
  logic          alu_ovf;
  logic          accept;
  logic [CW-1:0] cnt_inc;

  calc_accum_engine_alu #(.W(W)) u_alu (
    .op  (cmd_op),
    .a   (acc_q),
    .b   (cmd_data),
    .r   (alu_r),
    .ovf (alu_ovf)
  );

  assign cmd_ready = (state_q == ACCUM);
  assign res_valid = (state_q == RESULT);
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    res_cnt_d  = res_cnt_q;
    if (accept) begin
      acc_d  = alu_r;
      ovf_d  = ovf_q | alu_ovf;
      cnt_d  = cnt_inc;
      busy_d = 1'b1;
      // Result captures the post-update values on the same edge as ACC.
      if (cmd_last) begin
        res_data_d = alu_r;
        res_ovf_d  = ovf_q | alu_ovf;
        res_cnt_d  = cnt_inc;
        state_d    = RESULT;
      end
    end else if (res_valid && res_ready) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      busy_d  = 1'b0;
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      res_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_count = res_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_accum_engine.sv
// Directed bench for calc_accum_engine: hand-computed sequences, overflow, abs, backpressure,
// async reset and counter saturation. Inputs change 1 time unit after rising edges.
module tb_calc_accum_engine;
  import calc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_last;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_ovf;
  logic [7:0]  res_count;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  calc_accum_engine #(.W(16), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_last  (cmd_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .res_count (res_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat and hold it until the engine takes it; returns at posedge+1 after acceptance.
  task automatic send(input logic [2:0] op, input logic [15:0] d, input logic last);
    bit ok;
    int n;
    cmd_op    = op;
    cmd_data  = d;
    cmd_last  = last;
    cmd_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: cmd_ready stayed %b, required 1 within 20 cycles", cmd_ready);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({cmd_ready, res_valid, busy, res_ovf, res_data, res_count} !== {4'b1000, 16'h0000, 8'h00}) begin
      fails++;
      $display("FAIL reset_state: got rdy/vld/busy/ovf=%b%b%b%b data=%h cnt=%0d, required 1000 data=0000 cnt=0",
               cmd_ready, res_valid, busy, res_ovf, res_data, res_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send(OP_ADD_AB, 16'd5, 1'b0);
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_set: got %b, required 1", busy); end
    send(OP_SUB_AB, 16'd3, 1'b0);
    send(OP_ADD_BA, 16'd10, 1'b1);
    checks++;
    if (res_valid !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_latency: got vld=%b rdy=%b, required vld=1 rdy=0", res_valid, cmd_ready);
    end
    checks++;
    if ({res_data, res_ovf, res_count} !== {16'd12, 1'b0, 8'd3}) begin
      fails++;
      $display("FAIL basic_result: got data=%0d ovf=%b cnt=%0d, required 12 0 3", res_data, res_ovf, res_count);
    end
    handshake();
    checks++;
    if ({busy, cmd_ready, res_valid} !== 3'b010) begin
      fails++;
      $display("FAIL basic_release: got busy/rdy/vld=%b%b%b, required 010", busy, cmd_ready, res_valid);
    end
  endtask

  task automatic test_overflow();
    send(OP_ADD_AB, 16'd32767, 1'b0);
    send(OP_ADD_AB, 16'd1, 1'b1);
    checks++;
    if ({res_data, res_ovf, res_count} !== {16'h8000, 1'b1, 8'd2}) begin
      fails++;
      $display("FAIL ovf_result: got data=%h ovf=%b cnt=%0d, required 8000 1 2", res_data, res_ovf, res_count);
    end
    handshake();
    send(OP_ADD_AB, 16'd4, 1'b1);
    checks++;
    if ({res_data, res_ovf, res_count} !== {16'd4, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL ovf_cleared: got data=%0d ovf=%b cnt=%0d, required 4 0 1", res_data, res_ovf, res_count);
    end
    handshake();
  endtask

  task automatic test_abs();
    send(OP_ADD_AB, 16'hFFF9, 1'b0);
    send(3'b110, 16'h1234, 1'b0);
    checks++;
    if (dut.acc_q !== 16'd7) begin fails++; $display("FAIL abs_acc: got %0d, required 7", dut.acc_q); end
    send(3'b010, 16'h8000, 1'b1);
    checks++;
    if ({res_data, res_ovf, res_count} !== {16'h8000, 1'b1, 8'd3}) begin
      fails++;
      $display("FAIL abs_min: got data=%h ovf=%b cnt=%0d, required 8000 1 3", res_data, res_ovf, res_count);
    end
    handshake();
    send(OP_SUB_BA, 16'd20, 1'b1);
    checks++;
    if ({res_data, res_ovf, res_count} !== {16'd20, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL sub_ba: got data=%0d ovf=%b cnt=%0d, required 20 0 1", res_data, res_ovf, res_count);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    send(OP_SUB_AB, 16'd9, 1'b1);
    cmd_op    = OP_ADD_AB;
    cmd_data  = 16'd3;
    cmd_last  = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({cmd_ready, res_valid, res_data, res_ovf, res_count} !== {2'b01, 16'hFFF7, 1'b0, 8'd1}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b data=%h ovf=%b cnt=%0d, required 0 1 fff7 0 1",
                 i, cmd_ready, res_valid, res_data, res_ovf, res_count);
      end
    end
    handshake();
    checks++;
    if ({cmd_ready, res_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL bp_handshake: got rdy/vld/busy=%b%b%b, required 100", cmd_ready, res_valid, busy);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    checks++;
    if ({res_valid, res_data, res_count} !== {1'b1, 16'd3, 8'd1}) begin
      fails++;
      $display("FAIL bp_held_cmd: got vld=%b data=%0d cnt=%0d, required 1 3 1", res_valid, res_data, res_count);
    end
    handshake();
  endtask

  task automatic test_async_reset();
    send(OP_ADD_AB, 16'd100, 1'b0);
    send(OP_ADD_AB, 16'd50, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, res_valid, busy, res_ovf, res_data, res_count} !== {4'b1000, 16'h0000, 8'h00}) begin
      fails++;
      $display("FAIL async_reset: got rdy/vld/busy/ovf=%b%b%b%b data=%h cnt=%0d, required 1000 data=0000 cnt=0",
               cmd_ready, res_valid, busy, res_ovf, res_data, res_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(OP_ADD_AB, 16'd9, 1'b1);
    checks++;
    if ({res_data, res_ovf, res_count} !== {16'd9, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL after_reset: got data=%0d ovf=%b cnt=%0d, required 9 0 1", res_data, res_ovf, res_count);
    end
    handshake();
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 300; i++) begin
      send(OP_ADD_AB, 16'd0, (i == 300));
    end
    checks++;
    if ({res_valid, res_data, res_ovf, res_count} !== {1'b1, 16'd0, 1'b0, 8'd255}) begin
      fails++;
      $display("FAIL count_sat: got vld=%b data=%0d ovf=%b cnt=%0d, required 1 0 0 255",
               res_valid, res_data, res_ovf, res_count);
    end
    handshake();
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = 16'd0;
    cmd_last  = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_abs();
    test_backpressure();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
